// File: rtl/ldpc_rx_frame_ctrl.sv
// ldpc_rx_frame_ctrl: frames 12-bit receiver words into the LDPC LLR buffer and launches the decoder
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   word_valid, word_data     receiver word strobe and 12-bit word
//   buf_wr_en/addr/data       LLR buffer write port (registered, one cycle after the word)
//   dec_start, dec_len        decoder launch pulse and launched payload length
//   dec_done                  decoder completion pulse
//   busy                      high whenever a frame is in progress or the decoder runs
//   err_valid, err_code       error strobe; code 0 length, 1 checksum, 2 timeout, 3 overrun
//   frame_cnt                 number of frames launched
module ldpc_rx_frame_ctrl #(
    parameter int          MAX_LEN     = 512,
    parameter int          ADDR_W      = 9,
    parameter logic [11:0] SYNC_WORD   = 12'hA5A,
    parameter int          TIMEOUT_CYC = 100000,
    parameter int          CLK_FREQ    = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              word_valid,
    input  logic [11:0]       word_data,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [11:0]       buf_wr_data,
    output logic              dec_start,
    output logic [ADDR_W:0]   dec_len,
    input  logic              dec_done,
    output logic              busy,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [15:0]       frame_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYC);

    if ((1 << ADDR_W) < MAX_LEN || TIMEOUT_CYC < 2 || CLK_FREQ < 1) begin : g_bad_param
        $error("ldpc_rx_frame_ctrl: illegal parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_START, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, dec_len_q;
    logic [ADDR_W-1:0] idx_q, wr_addr_q;
    logic [11:0]       csum_q, wr_data_q;
    logic [TW-1:0]     tmo_q;
    logic              wr_en_q, err_valid_q, err_d;
    logic [1:0]        err_code_q, code_d;
    logic [15:0]       frame_cnt_q;
    logic              timed, tmo_hit, len_bad, last;

    assign timed   = state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM;
    // a word sampled on the deciding edge suppresses the timeout
    assign tmo_hit = timed && !word_valid && tmo_q == TW'(TIMEOUT_CYC - 2);
    assign len_bad = word_data == 12'd0 || word_data > 12'(MAX_LEN);
    assign last    = {1'b0, idx_q} == len_q - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        code_d  = err_code_q;
        case (state_q)
            S_IDLE:  if (word_valid && word_data == SYNC_WORD) state_d = S_LEN;
            S_LEN:   if (word_valid) begin
                         state_d = len_bad ? S_IDLE : S_DATA;
                         err_d   = len_bad;
                         code_d  = len_bad ? 2'd0 : err_code_q;
                     end
            S_DATA:  if (word_valid && last) state_d = S_CSUM;
            S_CSUM:  if (word_valid) begin
                         state_d = (word_data == csum_q) ? S_START : S_IDLE;
                         err_d   = word_data != csum_q;
                         code_d  = (word_data != csum_q) ? 2'd1 : err_code_q;
                     end
            S_START: begin
                         state_d = S_WAIT;
                         err_d   = word_valid;
                         code_d  = word_valid ? 2'd3 : err_code_q;
                     end
            S_WAIT:  begin
                         state_d = dec_done ? S_IDLE : S_WAIT;
                         err_d   = word_valid;
                         code_d  = word_valid ? 2'd3 : err_code_q;
                     end
            default: state_d = S_IDLE;
        endcase
        if (tmo_hit) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= '0;
            idx_q       <= '0;
            csum_q      <= '0;
            tmo_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            dec_len_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            tmo_q       <= (!timed || word_valid || state_d != state_q) ? '0 : tmo_q + 1'b1;
            wr_en_q     <= 1'b0;
            err_valid_q <= err_d;
            err_code_q  <= code_d;
            if (state_q == S_LEN && word_valid) begin
                len_q  <= word_data[ADDR_W:0];
                idx_q  <= '0;
                csum_q <= '0;
            end
            if (state_q == S_DATA && word_valid) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= idx_q;
                wr_data_q <= word_data;
                csum_q    <= csum_q ^ word_data;
                idx_q     <= idx_q + 1'b1;
            end
            // update on entry so dec_len and frame_cnt are valid alongside dec_start
            if (state_q == S_CSUM && state_d == S_START) begin
                dec_len_q   <= len_q;
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        busy      = state_q != S_IDLE;
        dec_start = state_q == S_START;
    end

    assign buf_wr_en   = wr_en_q;
    assign buf_wr_addr = wr_addr_q;
    assign buf_wr_data = wr_data_q;
    assign dec_len     = dec_len_q;
    assign err_valid   = err_valid_q;
    assign err_code    = err_code_q;
    assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_ldpc_rx_frame_ctrl.sv
// tb_ldpc_rx_frame_ctrl: directed self-checking bench for ldpc_rx_frame_ctrl
module tb_ldpc_rx_frame_ctrl;
    localparam int T = 40;
    localparam int AW = 9;

    logic          clk = 1'b0, rst = 1'b1, word_valid = 1'b0, dec_done = 1'b0;
    logic [11:0]   word_data = '0;
    logic          buf_wr_en, dec_start, busy, err_valid;
    logic [AW-1:0] buf_wr_addr;
    logic [11:0]   buf_wr_data;
    logic [AW:0]   dec_len;
    logic [1:0]    err_code;
    logic [15:0]   frame_cnt;
    int            tests = 0, fails = 0;

    ldpc_rx_frame_ctrl #(.MAX_LEN(512), .ADDR_W(AW), .SYNC_WORD(12'hA5A), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .word_valid(word_valid), .word_data(word_data),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .dec_start(dec_start), .dec_len(dec_len), .dec_done(dec_done), .busy(busy),
        .err_valid(err_valid), .err_code(err_code), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [11:0] w);
        word_valid = 1'b1;
        word_data  = w;
        @(posedge clk);
        #1 word_valid = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_en"}, buf_wr_en, 1);
        chk({tag, "_addr"}, buf_wr_addr, a);
        chk({tag, "_data"}, buf_wr_data, d);
    endtask

    task automatic done_pulse();
        dec_done = 1'b1;
        @(posedge clk);
        #1 dec_done = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_err", err_valid, 0);
        chk("rst_code", err_code, 0);
        chk("rst_start", dec_start, 0);
        chk("rst_wr", buf_wr_en, 0);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_len", dec_len, 0);
        send(12'h123);
        chk("idle_discard_busy", busy, 0);
        chk("idle_discard_err", err_valid, 0);
        send(12'hA5A);
        chk("sync_busy", busy, 1);
        send(12'h003);
        chk("len_nowr", buf_wr_en, 0);
        send(12'h011); wr("g0", 0, 12'h011);
        send(12'h022); wr("g1", 1, 12'h022);
        send(12'h044); wr("g2", 2, 12'h044);
        send(12'h077);
        chk("g_start", dec_start, 1);
        chk("g_len", dec_len, 3);
        chk("g_cnt", frame_cnt, 1);
        chk("g_nowr", buf_wr_en, 0);
        chk("g_noerr", err_valid, 0);
        @(posedge clk); #1;
        chk("g_start_pulse", dec_start, 0);
        chk("g_wait_busy", busy, 1);
        repeat (48) @(posedge clk);
        #1 chk("g_wait_busy2", busy, 1);
        done_pulse();
        chk("g_done_idle", busy, 0);
        send(12'hA5A); send(12'h000);
        chk("bl0_err", err_valid, 1);
        chk("bl0_code", err_code, 0);
        chk("bl0_busy", busy, 0);
        chk("bl0_nowr", buf_wr_en, 0);
        @(posedge clk); #1;
        chk("bl0_pulse", err_valid, 0);
        send(12'hA5A); send(12'h201);
        chk("bl513_err", err_valid, 1);
        chk("bl513_code", err_code, 0);
        chk("bl513_busy", busy, 0);
        send(12'hA5A); send(12'h002);
        send(12'hA5A); wr("sp0", 0, 12'hA5A);
        chk("sp_busy", busy, 1);
        send(12'h001); wr("sp1", 1, 12'h001);
        send(12'hA5B);
        chk("sp_start", dec_start, 1);
        chk("sp_len", dec_len, 2);
        chk("sp_cnt", frame_cnt, 2);
        chk("sp_code_held", err_code, 0);
        @(posedge clk); #1;
        done_pulse();
        chk("sp_idle", busy, 0);
        send(12'hA5A); send(12'h002);
        send(12'h0F0); wr("ck0", 0, 12'h0F0);
        send(12'h00F); wr("ck1", 1, 12'h00F);
        send(12'h0FE);
        chk("ck_err", err_valid, 1);
        chk("ck_code", err_code, 1);
        chk("ck_nostart", dec_start, 0);
        chk("ck_busy", busy, 0);
        chk("ck_cnt", frame_cnt, 2);
        send(12'hA5A); send(12'h004); send(12'h001);
        repeat (T - 2) @(posedge clk);
        #1 chk("to_early", err_valid, 0);
        chk("to_early_busy", busy, 1);
        @(posedge clk); #1;
        chk("to_err", err_valid, 1);
        chk("to_code", err_code, 2);
        chk("to_busy", busy, 0);
        send(12'hA5A); send(12'h004); send(12'h001);
        repeat (T - 2) @(posedge clk);
        #1 send(12'h002);
        chk("tw_noerr", err_valid, 0);
        wr("tw1", 1, 12'h002);
        send(12'h003); send(12'h004); wr("tw3", 3, 12'h004);
        send(12'h004);
        chk("tw_start", dec_start, 1);
        chk("tw_len", dec_len, 4);
        chk("tw_cnt", frame_cnt, 3);
        @(posedge clk); #1;
        send(12'h123);
        chk("ov_err", err_valid, 1);
        chk("ov_code", err_code, 3);
        chk("ov_busy", busy, 1);
        chk("ov_nostart", dec_start, 0);
        @(posedge clk); #1;
        chk("ov_hold", busy, 1);
        chk("ov_pulse", err_valid, 0);
        word_valid = 1'b1; word_data = 12'h456; dec_done = 1'b1;
        @(posedge clk);
        #1 word_valid = 1'b0; dec_done = 1'b0;
        chk("col_idle", busy, 0);
        chk("col_err", err_valid, 1);
        chk("col_code", err_code, 3);
        chk("col_cnt", frame_cnt, 3);
        send(12'hA5A); send(12'h005); send(12'h001); send(12'h002);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mr_busy", busy, 0);
        chk("mr_wr", buf_wr_en, 0);
        chk("mr_cnt", frame_cnt, 0);
        chk("mr_len", dec_len, 0);
        chk("mr_code", err_code, 0);
        send(12'hA5A); send(12'h001);
        send(12'h0AB); wr("mr0", 0, 12'h0AB);
        send(12'h0AB);
        chk("mr_start", dec_start, 1);
        chk("mr_cnt1", frame_cnt, 1);
        chk("mr_len1", dec_len, 1);
        @(posedge clk); #1;
        done_pulse();
        chk("mr_idle", busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ldpc_rx_frame_ctrl.md
Name: ldpc_rx_frame_ctrl

Overview:
Frame-level controller between the UART 12-bit word receiver and the LDPC decoder input buffer. It consumes the receiver's word strobe and 12-bit word, and hunts for a sync word. It parses the length word, writes payload words into the decoder LLR buffer and checks a XOR checksum. On a good frame it launches the decoder and holds off new frames until the decoder reports done. Malformed, stalled or overrun frames are aborted and reported through an error strobe.

Parameters:
MAX_LEN, 512, maximum payload words per frame (legal length 1..MAX_LEN)
ADDR_W, 9, buffer address width; must satisfy 2^ADDR_W >= MAX_LEN
SYNC_WORD, 12'hA5A, frame start marker
TIMEOUT_CYC, 100000, maximum clk cycles allowed between consecutive words inside a frame
CLK_FREQ, 100_000_000, informational only, no logic use

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
word_valid  in  1  one-cycle strobe, receiver word complete
word_data  in  12  receiver word, stable while word_valid is high
buf_wr_en  out  1  LLR buffer write strobe
buf_wr_addr  out  ADDR_W  LLR buffer write address
buf_wr_data  out  12  LLR buffer write data
dec_start  out  1  one-cycle decoder launch pulse
dec_len  out  ADDR_W+1  payload length of the launched frame
dec_done  in  1  one-cycle decoder completion pulse
busy  out  1  high in every state except S_IDLE
err_valid  out  1  one-cycle error strobe
err_code  out  2  0=bad length, 1=checksum mismatch, 2=timeout, 3=overrun; held until the next err_valid
frame_cnt  out  16  count of frames launched, wraps at 16'hFFFF->0

Behaviour:
- Reset: clk and synchronous reset only, rst is active-high. All outputs 0, state S_IDLE, checksum 0, timeout counter 0.
- States: S_IDLE, S_LEN, S_DATA, S_CSUM, S_START, S_WAIT.
- S_IDLE: if word_valid and word_data==SYNC_WORD, go to S_LEN. Any other word is discarded silently with no error.
- S_LEN: on word_valid, if word_data is 0 or greater than MAX_LEN, pulse err_valid with code 0 and go to S_IDLE. Otherwise latch len=word_data, clear index and checksum, go to S_DATA.
- S_DATA: on word_valid, buf_wr_en=1, buf_wr_addr=index, buf_wr_data=word_data, all registered so they appear the cycle after the strobe. Then checksum ^= word_data and index++. When index reaches len-1 on this word, go to S_CSUM.
- S_CSUM: on word_valid, compare word_data with the accumulated checksum.
  - Match: go to S_START.
  - Mismatch: err_valid with code 1, go to S_IDLE. Buffer contents are left stale and no dec_start is issued.
- S_START: dec_start=1 for exactly one cycle, dec_len=len (held until the next launch), frame_cnt++, go to S_WAIT.
- S_WAIT: stay until dec_done, then go to S_IDLE.
  - word_valid in S_START or S_WAIT: word dropped, err_valid with code 3. State is unchanged and the decoder is never disturbed.
  - dec_done outside S_WAIT is ignored.
- Timeout: the counter runs in S_LEN, S_DATA and S_CSUM and clears on every word_valid and on every state entry. When it reaches TIMEOUT_CYC-1 with no word: err_valid with code 2, go to S_IDLE. A word_valid arriving in that same cycle wins, so there is no timeout.
- No timeout in S_WAIT; the decoder may take arbitrarily long.
- Simultaneous word_valid and dec_done in S_WAIT: dec_done wins, state goes to S_IDLE, and the word is dropped with err code 3.
- Reset mid-frame: immediate return to S_IDLE. Partially written buffer data is abandoned and frame_cnt clears.
- At most one buf_wr_en per word_valid. The address never exceeds len-1.
- A SYNC_WORD value inside a payload is treated as data and never restarts a frame.

Test Plan:
- Good frame: A5A, 003, 011, 022, 044, 077 -> writes addr 0/1/2 = 011/022/044, one dec_start with dec_len=3, frame_cnt=1. busy stays high until dec_done is pulsed 50 cycles later, then returns to 0.
- Bad length: A5A, 000 -> err_valid with code 0 and no writes. Then A5A, length MAX_LEN+1 -> code 0. A following good frame is accepted normally.
- Checksum error: A5A, 002, 0F0, 00F, 0FE -> two writes, err_valid with code 1, no dec_start, frame_cnt unchanged.
- Timeout: A5A, 004, 001, then silence for TIMEOUT_CYC cycles -> err_valid with code 2 exactly TIMEOUT_CYC-1 cycles after the last strobe, then S_IDLE. Repeat with a word arriving at cycle TIMEOUT_CYC-1 -> no error.
- Overrun and collision: a word during S_WAIT -> code 3 and the state is held. A word in the same cycle as dec_done -> S_IDLE plus code 3.
- Reset mid-payload: assert rst after 2 of 5 payload words -> all outputs 0. The next full frame launches with frame_cnt=1.
